// File: rtl/fft8.sv
// 8-point radix-2 DIT FFT on complex Q8.8 samples: parallel capture, three
// butterfly stages (one per clock), parallel natural-order output bins.
module fft8 #(
  parameter int W    = 16,
  parameter int FRAC = 8
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         write,
  input  logic         start,
  input  logic [W-1:0] in0_real, in1_real, in2_real, in3_real,
  input  logic [W-1:0] in4_real, in5_real, in6_real, in7_real,
  input  logic [W-1:0] in0_imag, in1_imag, in2_imag, in3_imag,
  input  logic [W-1:0] in4_imag, in5_imag, in6_imag, in7_imag,
  output logic         ready,
  output logic [W-1:0] out0_real, out1_real, out2_real, out3_real,
  output logic [W-1:0] out4_real, out5_real, out6_real, out7_real,
  output logic [W-1:0] out0_imag, out1_imag, out2_imag, out3_imag,
  output logic [W-1:0] out4_imag, out5_imag, out6_imag, out7_imag,
  output logic [1:0]   fsm_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, S2 = 2'd1, S3 = 2'd2, DONE = 2'd3} state_t;

  typedef struct packed {
    logic [W-1:0] re;
    logic [W-1:0] im;
  } cplx_t;

  state_t       state, state_n;
  logic         ready_n, load_x, load_s, load_o;
  logic [W-1:0] in_re [8], in_im [8];
  logic [W-1:0] x_re  [8], x_im  [8];
  logic [W-1:0] stg_re[8], stg_im[8];
  logic [W-1:0] o_re  [8], o_im  [8];
  logic [W-1:0] src_re[8], src_im[8];
  logic [W-1:0] nxt_re[8], nxt_im[8];
  logic [2:0]   top, bot;
  logic [1:0]   k;
  cplx_t        t;

  assign in_re = '{in0_real, in1_real, in2_real, in3_real, in4_real, in5_real, in6_real, in7_real};
  assign in_im = '{in0_imag, in1_imag, in2_imag, in3_imag, in4_imag, in5_imag, in6_imag, in7_imag};

  assign out0_real = o_re[0];  assign out0_imag = o_im[0];
  assign out1_real = o_re[1];  assign out1_imag = o_im[1];
  assign out2_real = o_re[2];  assign out2_imag = o_im[2];
  assign out3_real = o_re[3];  assign out3_imag = o_im[3];
  assign out4_real = o_re[4];  assign out4_imag = o_im[4];
  assign out5_real = o_re[5];  assign out5_imag = o_im[5];
  assign out6_real = o_re[6];  assign out6_imag = o_im[6];
  assign out7_real = o_re[7];  assign out7_imag = o_im[7];
  assign fsm_state = state;

  function automatic logic [2:0] bitrev3(input logic [2:0] v);
    return {v[0], v[1], v[2]};
  endfunction

  // W8^k * b with 32-bit products, 33-bit sum, floor shift, 16-bit truncation.
  function automatic cplx_t cmul(input logic [W-1:0] b_re, input logic [W-1:0] b_im,
                                 input logic [1:0] kk);
    logic signed [W-1:0]   w_re, w_im;
    logic signed [2*W-1:0] p_rr, p_ii, p_ri, p_ir;
    logic signed [2*W:0]   s_re, s_im;
    cplx_t                 r;
    case (kk)
      2'd0:    begin w_re = W'(256);  w_im = W'(0);    end
      2'd1:    begin w_re = W'(181);  w_im = W'(-181); end
      2'd2:    begin w_re = W'(0);    w_im = W'(-256); end
      default: begin w_re = W'(-181); w_im = W'(-181); end
    endcase
    p_rr = (2*W)'($signed(b_re)) * (2*W)'(w_re);
    p_ii = (2*W)'($signed(b_im)) * (2*W)'(w_im);
    p_ri = (2*W)'($signed(b_re)) * (2*W)'(w_im);
    p_ir = (2*W)'($signed(b_im)) * (2*W)'(w_re);
    s_re = ((2*W+1)'(p_rr) - (2*W+1)'(p_ii)) >>> FRAC;
    s_im = ((2*W+1)'(p_ri) + (2*W+1)'(p_ir)) >>> FRAC;
    r.re = s_re[W-1:0];
    r.im = s_im[W-1:0];
    return r;
  endfunction

  // One shared butterfly bank; the state selects source, pairing distance and twiddles.
  always_comb begin
    top = 3'd0;
    bot = 3'd0;
    k   = 2'd0;
    t   = '0;
    for (int i = 0; i < 8; i++) begin
      src_re[3'(i)] = (state == IDLE) ? x_re[3'(i)] : stg_re[3'(i)];
      src_im[3'(i)] = (state == IDLE) ? x_im[3'(i)] : stg_im[3'(i)];
      nxt_re[3'(i)] = src_re[3'(i)];
      nxt_im[3'(i)] = src_im[3'(i)];
    end
    for (int b = 0; b < 4; b++) begin
      case (state)
        IDLE: begin top = 3'(2 * b);               bot = top + 3'd1; k = 2'd0;            end
        S2:   begin top = 3'((b / 2) * 4 + b % 2); bot = top + 3'd2; k = 2'((b % 2) * 2); end
        default: begin top = 3'(b);                bot = top + 3'd4; k = 2'(b);           end
      endcase
      t = cmul(src_re[bot], src_im[bot], k);
      nxt_re[top] = src_re[top] + t.re;
      nxt_im[top] = src_im[top] + t.im;
      nxt_re[bot] = src_re[top] - t.re;
      nxt_im[bot] = src_im[top] - t.im;
    end
  end

  always_comb begin
    state_n = state;
    ready_n = ready;
    load_x  = 1'b0;
    load_s  = 1'b0;
    load_o  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load_s  = 1'b1;
          state_n = S2;
        end else if (write) begin
          load_x  = 1'b1;
        end
      end
      S2: begin
        load_s  = 1'b1;
        state_n = S3;
      end
      S3: begin
        load_o  = 1'b1;
        ready_n = 1'b1;
        state_n = DONE;
      end
      default: begin
        if (!start) begin
          ready_n = 1'b0;
          state_n = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      ready <= 1'b0;
    end else begin
      state <= state_n;
      ready <= ready_n;
    end
  end

  // Input file is stored bit-reversed so every stage reads in place.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < 8; i++) begin
        x_re[3'(i)]   <= '0;  x_im[3'(i)]   <= '0;
        stg_re[3'(i)] <= '0;  stg_im[3'(i)] <= '0;
        o_re[3'(i)]   <= '0;  o_im[3'(i)]   <= '0;
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (load_x) begin
          x_re[3'(i)] <= in_re[bitrev3(3'(i))];
          x_im[3'(i)] <= in_im[bitrev3(3'(i))];
        end
        if (load_s) begin
          stg_re[3'(i)] <= nxt_re[3'(i)];
          stg_im[3'(i)] <= nxt_im[3'(i)];
        end
        if (load_o) begin
          o_re[3'(i)] <= nxt_re[3'(i)];
          o_im[3'(i)] <= nxt_im[3'(i)];
        end
      end
    end
  end

endmodule

// File: tb/tb_fft8.sv
// Directed bench for fft8: table of hand-computed transforms plus handshake,
// latency and asynchronous-reset sequences.
module tb_fft8;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        write = 1'b0;
  logic        start = 1'b0;
  logic [15:0] in_re [8];
  logic [15:0] in_im [8];
  logic [15:0] out_re[8];
  logic [15:0] out_im[8];
  logic        ready;
  logic [1:0]  fsm_state;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       name;
    logic [15:0] in_re[8];
    logic [15:0] in_im[8];
    logic [15:0] ex_re[8];
    logic [15:0] ex_im[8];
  } vec_t;

  vec_t vecs[7];

  fft8 dut (
    .CLK(CLK), .RST_N(RST_N), .write(write), .start(start),
    .in0_real(in_re[0]), .in1_real(in_re[1]), .in2_real(in_re[2]), .in3_real(in_re[3]),
    .in4_real(in_re[4]), .in5_real(in_re[5]), .in6_real(in_re[6]), .in7_real(in_re[7]),
    .in0_imag(in_im[0]), .in1_imag(in_im[1]), .in2_imag(in_im[2]), .in3_imag(in_im[3]),
    .in4_imag(in_im[4]), .in5_imag(in_im[5]), .in6_imag(in_im[6]), .in7_imag(in_im[7]),
    .ready(ready),
    .out0_real(out_re[0]), .out1_real(out_re[1]), .out2_real(out_re[2]), .out3_real(out_re[3]),
    .out4_real(out_re[4]), .out5_real(out_re[5]), .out6_real(out_re[6]), .out7_real(out_re[7]),
    .out0_imag(out_im[0]), .out1_imag(out_im[1]), .out2_imag(out_im[2]), .out3_imag(out_im[3]),
    .out4_imag(out_im[4]), .out5_imag(out_im[5]), .out6_imag(out_im[6]), .out7_imag(out_im[7]),
    .fsm_state(fsm_state)
  );

  // Clock and watchdog
  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Driver tasks
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input int v);
    for (int i = 0; i < 8; i++) begin
      in_re[i] = vecs[v].in_re[i];
      in_im[i] = vecs[v].in_im[i];
    end
  endtask

  task automatic load(input int v);
    drive(v);
    write = 1'b1;
    tick();
    write = 1'b0;
  endtask

  task automatic check_bins(input int v, input string tag);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("%s out%0d_real", tag, i), out_re[i], vecs[v].ex_re[i]);
      check($sformatf("%s out%0d_imag", tag, i), out_im[i], vecs[v].ex_im[i]);
    end
  endtask

  // mode 0: plain run; 1: write high on the start edge; 2: write high in S2
  task automatic run_expect(input int v, input int mode, input string tag);
    start = 1'b1;
    if (mode == 1) write = 1'b1;
    tick();
    write = 1'b0;
    check({tag, " ready after edge 1"}, 16'(ready), 16'd0);
    if (mode == 2) write = 1'b1;
    tick();
    write = 1'b0;
    check({tag, " ready after edge 2"}, 16'(ready), 16'd0);
    tick();
    check({tag, " ready after edge 3"}, 16'(ready), 16'd1);
    check({tag, " state DONE"}, 16'(fsm_state), 16'd3);
    check_bins(v, tag);
    start = 1'b0;
    tick();
    check({tag, " ready cleared"}, 16'(ready), 16'd0);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      in_re[i] = '0;
      in_im[i] = '0;
    end

    vecs[0].name  = "impulse";
    vecs[0].in_re = '{16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    vecs[0].in_im = '{default: 16'h0000};
    vecs[0].ex_re = '{default: 16'h0100};
    vecs[0].ex_im = '{default: 16'h0000};

    vecs[1].name  = "imag_impulse";
    vecs[1].in_re = '{default: 16'h0000};
    vecs[1].in_im = '{16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    vecs[1].ex_re = '{default: 16'h0000};
    vecs[1].ex_im = '{default: 16'h0100};

    vecs[2].name  = "dc";
    vecs[2].in_re = '{default: 16'h0100};
    vecs[2].in_im = '{default: 16'h0000};
    vecs[2].ex_re = '{16'h0800, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    vecs[2].ex_im = '{default: 16'h0000};

    // in1 = 1.0: bin k equals the twiddle W8^k
    vecs[3].name  = "shifted_impulse";
    vecs[3].in_re = '{16'h0000, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    vecs[3].in_im = '{default: 16'h0000};
    vecs[3].ex_re = '{16'h0100, 16'h00B5, 16'h0000, 16'hFF4B, 16'hFF00, 16'hFF4B, 16'h0000, 16'h00B5};
    vecs[3].ex_im = '{16'h0000, 16'hFF4B, 16'hFF00, 16'hFF4B, 16'h0000, 16'h00B5, 16'h0100, 16'h00B5};

    // in1 = 1 LSB: negative products floor to -1 instead of rounding to 0
    vecs[4].name  = "floor_lsb";
    vecs[4].in_re = '{16'h0000, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    vecs[4].in_im = '{default: 16'h0000};
    vecs[4].ex_re = '{16'h0001, 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 16'h0001};
    vecs[4].ex_im = '{16'h0000, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0001, 16'h0001, 16'h0001};

    vecs[5].name  = "ramp";
    vecs[5].in_re = '{16'h0000, 16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0500, 16'h0600, 16'h0700};
    vecs[5].in_im = '{default: 16'h0000};
    vecs[5].ex_re = '{16'h1C00, 16'hFC00, 16'hFC00, 16'hFC00, 16'hFC00, 16'hFC00, 16'hFC00, 16'hFC00};
    vecs[5].ex_im = '{16'h0000, 16'h09A8, 16'h0400, 16'h01A8, 16'h0000, 16'hFE58, 16'hFC00, 16'hF658};

    vecs[6].name  = "overflow";
    vecs[6].in_re = '{default: 16'h2000};
    vecs[6].in_im = '{default: 16'h0000};
    vecs[6].ex_re = '{default: 16'h0000};
    vecs[6].ex_im = '{default: 16'h0000};

    // Reset state
    tick();
    tick();
    check("reset ready", 16'(ready), 16'd0);
    check("reset state", 16'(fsm_state), 16'd0);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("reset out%0d_real", i), out_re[i], 16'h0000);
      check($sformatf("reset out%0d_imag", i), out_im[i], 16'h0000);
    end
    RST_N = 1'b1;
    tick();

    // Table-driven transforms
    for (int v = 0; v < 7; v++) begin
      load(v);
      run_expect(v, 0, vecs[v].name);
    end

    // Start held high: DONE holds, no re-run; dropping start returns to IDLE
    load(5);
    start = 1'b1;
    tick();
    tick();
    tick();
    for (int c = 0; c < 4; c++) begin
      tick();
      check($sformatf("hold ready c%0d", c), 16'(ready), 16'd1);
      check($sformatf("hold state c%0d", c), 16'(fsm_state), 16'd3);
      check($sformatf("hold out1_imag c%0d", c), out_im[1], 16'h09A8);
    end
    start = 1'b0;
    tick();
    check("done->idle ready", 16'(ready), 16'd0);
    check("done->idle state", 16'(fsm_state), 16'd0);
    check("retained out0_real", out_re[0], 16'h1C00);
    check("retained out7_imag", out_im[7], 16'hF658);

    // write with start on the same edge: old capture is transformed
    load(0);
    drive(2);
    run_expect(0, 1, "write_with_start");
    run_expect(0, 0, "rerun_after_write_with_start");

    // write during S2 is ignored, also for later runs
    load(5);
    drive(2);
    run_expect(5, 2, "write_in_s2");
    run_expect(5, 0, "rerun_after_write_in_s2");

    // Asynchronous reset during S2
    load(3);
    start = 1'b1;
    tick();
    check("pre-reset state S2", 16'(fsm_state), 16'd1);
    #2;
    RST_N = 1'b0;
    #1;
    check("async reset ready", 16'(ready), 16'd0);
    check("async reset state", 16'(fsm_state), 16'd0);
    check("async reset out0_real", out_re[0], 16'h0000);
    check("async reset out7_imag", out_im[7], 16'h0000);
    start = 1'b0;
    tick();
    RST_N = 1'b1;
    tick();
    // input file was cleared, so a run without a fresh write yields all zeros
    run_expect(6, 0, "after_async_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
